// File: rtl/cic_pkg.sv
// Shared types and widths for the CIC rate controller.
package cic_pkg;

    localparam int unsigned RateBits   = 16;
    localparam int unsigned SettleBits = 32;

    typedef enum logic [1:0] {
        ST_RESET_DP = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_RUN      = 2'd2
    } cic_state_t;

    // Input strobes needed to flush every integrator/comb stage at a given rate.
    function automatic logic [SettleBits-1:0] settle_target(
        input int unsigned          order,
        input logic [RateBits-1:0]  rate
    );
        return SettleBits'(order + 1) * SettleBits'(rate);
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Counts accepted input strobes during settle and flags the strobe that hits the target.
module settle_counter
    import cic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [SettleBits-1:0] target,
    output logic                  done
);

    logic [SettleBits-1:0] count;
    logic [SettleBits-1:0] target_q;

    // Target is captured while cleared so it tracks the rate loaded for this settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            target_q <= '0;
        end else if (clear) begin
            count    <= '0;
            target_q <= target;
        end else if (enable && (count < target_q)) begin
            count <= count + SettleBits'(1);
        end
    end

    // Count never exceeds target, so the +1 cannot wrap.
    assign done = enable && ((count + SettleBits'(1)) >= target_q);

endmodule

// File: rtl/cic_rate_ctrl.sv
// Sequences reset, settle and run phases of a CIC decimator around rate changes.
module cic_rate_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned DefaultRate = 50,
    parameter int unsigned MaxRate     = 4096,
    parameter int unsigned CicOrder    = 5,
    parameter int unsigned ResetCycles = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RateBits-1:0] cfg_rate,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic                cfg_err,
    input  logic                src_valid,
    output logic                dp_rst,
    output logic [RateBits-1:0] dp_rate,
    output logic                dp_in_valid,
    input  logic                dp_out_valid,
    output logic                dp_out_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                locked
);

    localparam int unsigned RstCntBits = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;

    cic_state_t            state, state_next;
    logic [RstCntBits-1:0] rst_cnt, rst_cnt_next;
    logic                  cfg_fire;
    logic                  rate_ok;
    logic                  cfg_load;
    logic                  cfg_bad;
    logic                  settle_clear;
    logic                  settle_enable;
    logic                  settle_done;

    assign cfg_fire = cfg_valid && cfg_ready;
    assign rate_ok  = (cfg_rate != '0) && (32'(cfg_rate) <= 32'(MaxRate));
    assign cfg_load = cfg_fire && rate_ok;
    assign cfg_bad  = cfg_fire && !rate_ok;

    // A sample coinciding with a rate change belongs to the old settle, so it is not counted.
    assign settle_clear  = (state != ST_SETTLE);
    assign settle_enable = (state == ST_SETTLE) && src_valid && !cfg_load;

    settle_counter u_settle (
        .clk    (clk),
        .rst    (rst),
        .clear  (settle_clear),
        .enable (settle_enable),
        .target (settle_target(CicOrder, dp_rate)),
        .done   (settle_done)
    );

    // State, rate and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RESET_DP;
            rst_cnt   <= '0;
            dp_rate   <= RateBits'(DefaultRate);
            cfg_err   <= 1'b0;
            dp_rst    <= 1'b1;
            cfg_ready <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_next;
            rst_cnt   <= rst_cnt_next;
            cfg_err   <= cfg_bad;
            dp_rst    <= (state_next == ST_RESET_DP);
            cfg_ready <= (state_next != ST_RESET_DP);
            locked    <= (state_next == ST_RUN);
            if (cfg_load) begin
                dp_rate <= cfg_rate;
            end
        end
    end

    // Next-state logic; a valid config always restarts from RESET_DP.
    always_comb begin
        state_next   = state;
        rst_cnt_next = '0;
        case (state)
            ST_RESET_DP: begin
                if (rst_cnt == RstCntBits'(ResetCycles - 1)) begin
                    state_next = ST_SETTLE;
                end else begin
                    rst_cnt_next = rst_cnt + RstCntBits'(1);
                end
            end
            ST_SETTLE: begin
                if (cfg_load) begin
                    state_next = ST_RESET_DP;
                end else if (settle_done) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_load) begin
                    state_next = ST_RESET_DP;
                end
            end
            default: state_next = ST_RESET_DP;
        endcase
    end

    // Strobe gating and output pass-through follow the current state in the same cycle.
    always_comb begin
        dp_in_valid  = 1'b0;
        dp_out_ready = 1'b1;
        out_valid    = 1'b0;
        case (state)
            ST_SETTLE: dp_in_valid = src_valid;
            ST_RUN: begin
                dp_in_valid  = src_valid;
                dp_out_ready = out_ready;
                out_valid    = dp_out_valid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Randomised directed bench for cic_rate_ctrl against a phase/strobe-count reference model.
module tb_cic_rate_ctrl;

    localparam int unsigned DefaultRate = 50;
    localparam int unsigned MaxRate     = 4096;
    localparam int unsigned CicOrder    = 5;
    localparam int unsigned ResetCycles = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_rate;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_err;
    logic        src_valid;
    logic        dp_rst;
    logic [15:0] dp_rate;
    logic        dp_in_valid;
    logic        dp_out_valid;
    logic        dp_out_ready;
    logic        out_valid;
    logic        out_ready;
    logic        locked;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = datapath in reset, 1 = settling, 2 = running.
    int m_phase;
    int m_rcnt;
    int m_strobes;
    int m_target;
    int m_rate;
    int m_err;

    always #5 clk = ~clk;

    cic_rate_ctrl #(
        .DefaultRate (DefaultRate),
        .MaxRate     (MaxRate),
        .CicOrder    (CicOrder),
        .ResetCycles (ResetCycles)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_rate     (cfg_rate),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err),
        .src_valid    (src_valid),
        .dp_rst       (dp_rst),
        .dp_rate      (dp_rate),
        .dp_in_valid  (dp_in_valid),
        .dp_out_valid (dp_out_valid),
        .dp_out_ready (dp_out_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .locked       (locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic rb(input int pct);
        return ($urandom_range(99) < 32'(pct));
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_rcnt    = 0;
        m_strobes = 0;
        m_target  = 0;
        m_rate    = DefaultRate;
        m_err     = 0;
    endtask

    // Advance the model across one rising edge given this cycle's inputs.
    task automatic model_step();
        int fire;
        int ok;
        if (rst) begin
            model_reset();
        end else begin
            fire  = (cfg_valid && m_phase != 0) ? 1 : 0;
            ok    = (cfg_rate >= 1 && 32'(cfg_rate) <= MaxRate) ? 1 : 0;
            m_err = (fire == 1 && ok == 0) ? 1 : 0;
            if (fire == 1 && ok == 1) begin
                m_rate  = int'(cfg_rate);
                m_phase = 0;
                m_rcnt  = 0;
            end else if (m_phase == 0) begin
                m_rcnt++;
                if (m_rcnt == ResetCycles) begin
                    m_phase   = 1;
                    m_strobes = 0;
                    m_target  = (CicOrder + 1) * m_rate;
                end
            end else if (m_phase == 1 && src_valid) begin
                m_strobes++;
                if (m_strobes == m_target) m_phase = 2;
            end
        end
    endtask

    task automatic tick(input logic r, input logic cv, input logic [15:0] cr,
                        input logic sv, input logic dov, input logic ordy);
        rst          = r;
        cfg_valid    = cv;
        cfg_rate     = cr;
        src_valid    = sv;
        dp_out_valid = dov;
        out_ready    = ordy;
        #1;
        chk("dp_rst",       32'(dp_rst),       32'(m_phase == 0));
        chk("cfg_ready",    32'(cfg_ready),    32'(m_phase != 0));
        chk("locked",       32'(locked),       32'(m_phase == 2));
        chk("cfg_err",      32'(cfg_err),      32'(m_err));
        chk("dp_rate",      32'(dp_rate),      32'(m_rate));
        chk("dp_in_valid",  32'(dp_in_valid),  32'(m_phase != 0 && sv));
        chk("out_valid",    32'(out_valid),    32'(m_phase == 2 && dov));
        chk("dp_out_ready", 32'(dp_out_ready), 32'((m_phase == 2) ? ordy : 1'b1));
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_rand(input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, 1'b0, 16'd0, rb(70), rb(50), rb(50));
    endtask

    task automatic run_until_locked(input int budget);
        int n = 0;
        while (m_phase != 2 && n < budget) begin
            tick(1'b0, 1'b0, 16'd0, rb(75), rb(50), rb(50));
            n++;
        end
        checks++;
        assert (m_phase == 2) else begin
            errors++;
            $error("FAIL lock_timeout: observed phase %0d expected 2 within %0d cycles", m_phase, budget);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_rate = '0;
        src_valid = 1'b0; dp_out_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset hold, then default-rate settle of 300 strobes.
        for (int i = 0; i < 3; i++) tick(1'b1, rb(50), 16'd10, rb(50), rb(50), rb(50));
        run_until_locked(2000);
        idle_rand(10);

        // Output pass-through while running.
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 16'd0, rb(50), 1'b1, i[0]);

        // Rate change to 10 while running.
        tick(1'b0, 1'b1, 16'd10, 1'b1, 1'b1, 1'b0);
        run_until_locked(400);
        idle_rand(5);

        // Out-of-range configs leave everything alone.
        tick(1'b0, 1'b1, 16'd0, rb(50), 1'b1, 1'b1);
        tick(1'b0, 1'b0, 16'd0, rb(50), 1'b1, 1'b1);
        tick(1'b0, 1'b1, 16'd5000, rb(50), 1'b1, 1'b1);
        tick(1'b0, 1'b1, 16'(MaxRate + 1), rb(50), 1'b1, 1'b1);
        idle_rand(4);

        // Settle with outputs stalled downstream, plus a same-rate restart mid-settle.
        tick(1'b0, 1'b1, 16'd3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 16'd3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && m_phase != 2; i++) tick(1'b0, 1'b0, 16'd0, rb(80), 1'b1, 1'b0);
        run_until_locked(100);

        // Boundary rates: MaxRate accepted, then replaced by rate 1 mid-settle.
        tick(1'b0, 1'b1, 16'(MaxRate), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 16'd0, rb(80), rb(50), rb(50));
        tick(1'b0, 1'b1, 16'd1, 1'b1, 1'b0, 1'b1);
        run_until_locked(50);

        // Reset pulse partway through a 300-strobe settle.
        tick(1'b0, 1'b1, 16'd50, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400 && !(m_phase == 1 && m_strobes == 150); i++)
            tick(1'b0, 1'b0, 16'd0, rb(75), rb(50), rb(50));
        chk("strobes_before_rst", 32'(m_strobes), 32'd150);
        tick(1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
        run_until_locked(2000);

        // Free-running random traffic with occasional configs and resets.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] r;
            case ($urandom_range(3))
                0: r = 16'd0;
                1: r = 16'd5000;
                default: r = 16'($urandom_range(12, 1));
            endcase
            tick(rb(1), rb(3), r, rb(70), rb(50), rb(50));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_rate_ctrl.md
CIC_RATE_CTRL -- requirements
Module: cic_rate_ctrl

Interface
REQ-001 SHALL have parameter DefaultRate, default 50: decimation factor loaded at reset.
REQ-002 SHALL have parameter MaxRate, default 4096: largest accepted decimation factor.
REQ-003 SHALL have parameter CicOrder, default 5: number of CIC stages, used for the settle length.
REQ-004 SHALL have parameter ResetCycles, default 2: length of the datapath reset pulse, in cycles.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port cfg_rate, input, 16 bits: requested decimation factor, unsigned.
REQ-008 SHALL have port cfg_valid, input, 1 bit; cfg_ready, output, 1 bit: config handshake; transfer when both are high.
REQ-009 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an accepted cfg_rate is out of range.
REQ-010 SHALL have port src_valid, input, 1 bit: input-sample strobe from the upstream source.
REQ-011 SHALL have port dp_rst, output, 1 bit: synchronous reset to the CIC datapath.
REQ-012 SHALL have port dp_rate, output, 16 bits: decimation factor driven to the datapath.
REQ-013 SHALL have port dp_in_valid, output, 1 bit: gated sample strobe to the datapath.
REQ-014 SHALL have port dp_out_valid, input, 1 bit; dp_out_ready, output, 1 bit: datapath output handshake.
REQ-015 SHALL have port out_valid, output, 1 bit; out_ready, input, 1 bit: downstream output handshake.
REQ-016 SHALL have port locked, output, 1 bit: high only in state RUN.

Function
REQ-017 SHALL implement exactly three states: RESET_DP, SETTLE and RUN.
REQ-018 In RESET_DP, SHALL drive dp_rst=1, dp_in_valid=0, dp_out_ready=1, out_valid=0 and cfg_ready=0, for exactly ResetCycles cycles, then go to SETTLE.
REQ-019 On entry to SETTLE, SHALL clear the settle counter (32-bit) and SHALL set the settle target to (CicOrder+1)*dp_rate, computed at 32-bit width with no truncation.
REQ-020 In SETTLE, SHALL drive dp_rst=0, dp_in_valid=src_valid, dp_out_ready=1, out_valid=0 and cfg_ready=1, so that datapath outputs are drained and discarded.
REQ-021 In SETTLE, SHALL increment the settle counter on each src_valid, and SHALL go to RUN on the cycle after the counter reaches the settle target.
REQ-022 In RUN, SHALL drive dp_in_valid=src_valid, out_valid=dp_out_valid, dp_out_ready=out_ready (combinational pass-through) and cfg_ready=1.
REQ-023 A config transfer with 1 <= cfg_rate <= MaxRate SHALL load dp_rate on the next edge and enter RESET_DP, from either SETTLE or RUN.
REQ-024 A config with the same value as the current dp_rate SHALL still restart the sequence (RESET_DP).
REQ-025 A config transfer with cfg_rate=0 or cfg_rate>MaxRate SHALL complete the handshake, pulse cfg_err for one cycle, and leave state and dp_rate unchanged.
REQ-026 src_valid strobes arriving in RESET_DP SHALL be dropped and not counted.
REQ-027 A valid config arriving on the same cycle as src_valid in SETTLE or RUN SHALL forward that sample via dp_in_valid, and SHALL not count it toward the new settle.
REQ-028 The settle counter SHALL never wrap, since the maximum target (CicOrder+1)*MaxRate fits in 32 bits.

Reset
REQ-029 While rst=1, SHALL hold dp_rate=DefaultRate, cfg_err=0, locked=0 and the settle counter=0, with state forced to RESET_DP and its cycle counter cleared.
REQ-030 After rst falls, SHALL run a full ResetCycles RESET_DP pulse; rst asserted mid-SETTLE or mid-RUN SHALL abandon that state immediately.

Structure
REQ-031 SHALL place RateBits=16, SettleBits=32 and the state enum type in shared package cic_pkg.
REQ-032 SHALL implement the settle count and target compare as one sub-module, settle_counter (clear, enable, target, done).

Verification
REQ-033 Reset with DefaultRate=50 and CicOrder=5 -> dp_rst high for 2 cycles; locked rises on the cycle after the 300th src_valid; no out_valid before that.
REQ-034 In RUN, write cfg_rate=10 -> cfg_ready low for 2 cycles, dp_rate=10, dp_rst pulse of 2 cycles; locked after 60 further strobes.
REQ-035 Write cfg_rate=0, then cfg_rate=5000 -> two single-cycle cfg_err pulses; dp_rate and locked unchanged.
REQ-036 In SETTLE, with dp_out_valid forced high and out_ready=0 -> dp_out_ready=1 and out_valid=0 throughout.
REQ-037 In RUN, toggle out_ready with dp_out_valid=1 -> dp_out_ready equals out_ready in the same cycle.
REQ-038 Assert rst for 1 cycle at settle count 150 -> counter cleared, RESET_DP reentered, and the full 300-strobe settle repeated.
